// File: rtl/wb_logic_pkg.sv
// Shared definitions for the Wishbone-fed logic block: register map,
// sequencing FSM states and STATUS/CTRL bit layout.
package wb_logic_pkg;

    localparam logic [4:0] ADR_OP_C   = 5'h00;
    localparam logic [4:0] ADR_OP_D   = 5'h04;
    localparam logic [4:0] ADR_CTRL   = 5'h08;
    localparam logic [4:0] ADR_STATUS = 5'h0C;
    localparam logic [4:0] ADR_RES_A  = 5'h10;
    localparam logic [4:0] ADR_RES_B  = 5'h14;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int CTRL_START_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    typedef enum logic [2:0] {
        REG_OP_C   = 3'd0,
        REG_OP_D   = 3'd1,
        REG_CTRL   = 3'd2,
        REG_STATUS = 3'd3,
        REG_RES_A  = 3'd4,
        REG_RES_B  = 3'd5,
        REG_NONE   = 3'd6
    } reg_sel_e;

    // Full 5-bit compare, so unaligned byte addresses fall out as unmapped.
    function automatic reg_sel_e decode_addr(input logic [4:0] adr);
        reg_sel_e sel;
        case (adr)
            ADR_OP_C:   sel = REG_OP_C;
            ADR_OP_D:   sel = REG_OP_D;
            ADR_CTRL:   sel = REG_CTRL;
            ADR_STATUS: sel = REG_STATUS;
            ADR_RES_A:  sel = REG_RES_A;
            ADR_RES_B:  sel = REG_RES_B;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_logic_regs.sv
// Wishbone classic register front end for the logic feeder: address decode,
// one-cycle ack/err responses, read mux and the operand registers.
module wb_logic_regs
    import wb_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    input  logic             busy,
    input  logic             done,
    input  logic [WIDTH-1:0] res_a,
    input  logic [WIDTH-1:0] res_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic             start
);

    // Handshake: a request is cyc&stb sampled on a rising edge; it is answered
    // by exactly one ack or err pulse in the following cycle, and the cycle that
    // carries a response is never itself taken as a new request.
    logic        resp_now;
    logic        req;
    reg_sel_e    sel;
    logic        reject;
    logic        wr_ok;
    logic        rd_ok;
    logic [31:0] rdata;
    logic        unused_dat;

    assign resp_now   = wb_ack_o | wb_err_o;
    assign req        = wb_cyc_i & wb_stb_i & ~resp_now;
    assign sel        = decode_addr(wb_adr_i);
    assign wr_ok      = req & wb_we_i & ~reject;
    assign rd_ok      = req & ~wb_we_i & ~reject;
    assign start      = wr_ok & (sel == REG_CTRL) & wb_dat_i[CTRL_START_BIT];
    assign unused_dat = ^wb_dat_i;

    always_comb begin
        reject = 1'b0;
        case (sel)
            REG_OP_C, REG_OP_D, REG_CTRL:     reject = wb_we_i & busy;
            REG_STATUS, REG_RES_A, REG_RES_B: reject = wb_we_i;
            default:                          reject = 1'b1;
        endcase
    end

    // CTRL is write-only and reads back as zero.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_OP_C:  rdata[WIDTH-1:0] = op_c;
            REG_OP_D:  rdata[WIDTH-1:0] = op_d;
            REG_STATUS: begin
                rdata[STAT_BUSY_BIT] = busy;
                rdata[STAT_DONE_BIT] = done;
            end
            REG_RES_A: rdata[WIDTH-1:0] = res_a;
            REG_RES_B: rdata[WIDTH-1:0] = res_b;
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            op_c     <= '0;
            op_d     <= '0;
        end else begin
            wb_ack_o <= req & ~reject;
            wb_err_o <= req & reject;
            wb_dat_o <= rd_ok ? rdata : '0;
            if (wr_ok && sel == REG_OP_C) begin
                op_c <= wb_dat_i[WIDTH-1:0];
            end
            if (wr_ok && sel == REG_OP_D) begin
                op_d <= wb_dat_i[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_logic_feeder.sv
// Feeds two operands to an external AND/OR stage of fixed latency and
// captures its results, controlled through a Wishbone classic register file.
module wb_logic_feeder
    import wb_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic [WIDTH-1:0] c_o,
    output logic [WIDTH-1:0] d_o,
    output logic             issue_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    fsm_state_e       state_q;
    fsm_state_e       state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic             capture;
    logic             start;
    logic             busy;
    logic             done_q;
    logic [WIDTH-1:0] op_c;
    logic [WIDTH-1:0] op_d;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] res_a_q;
    logic [WIDTH-1:0] res_b_q;

    wb_logic_regs #(
        .WIDTH(WIDTH)
    ) u_regs (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .busy     (busy),
        .done     (done_q),
        .res_a    (res_a_q),
        .res_b    (res_b_q),
        .op_c     (op_c),
        .op_d     (op_d),
        .start    (start)
    );

    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign issue_o   = (state_q == ST_ISSUE);
    assign c_o       = c_q;
    assign d_o       = d_q;
    assign dbg_state = state_q;

    // The counter holds LAT during ISSUE and hits zero in the cycle that is
    // LAT cycles after issue_o, which is when the results are sampled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    cnt_d   = LAT_CNT;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // A start accepted in the DONE cycle must not be lost.
                if (start) begin
                    state_d = ST_ISSUE;
                    cnt_d   = LAT_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                c_q    <= op_c;
                d_q    <= op_d;
                done_q <= 1'b0;
            end
            if (capture) begin
                res_a_q <= a_i;
                res_b_q <= b_i;
                done_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_logic_feeder.sv
// Bench for wb_logic_feeder: three instances (8b/LAT1, 8b/LAT4, 1b/LAT1) behind
// one shared Wishbone driver, with a transaction-level model of the register map.
module tb_wb_logic_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cyc;
    logic        stb;
    logic        we;
    logic [4:0]  adr;
    logic [31:0] wdat;

    logic        ack_w [3];
    logic        err_w [3];
    logic        iss_w [3];
    logic [31:0] dat_w [3];
    logic [31:0] c_w   [3];
    logic [31:0] d_w   [3];

    int unsigned cyc_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic        mon_en = 1'b0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int lat_of(input int s);
        return (s == 1) ? 4 : 1;
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        return (s == 2) ? 32'h1 : 32'hFF;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 2) ? 1 : 8;
        localparam int L = (g == 1) ? 4 : 1;
        logic [W-1:0] c, d, a, b;
        logic [31:0]  rd;
        logic         ack, err, iss;
        logic [1:0]   st;
        logic [4:0]   since;

        wb_logic_feeder #(.WIDTH(W), .LAT(L)) u_dut (
            .clk(clk), .rst(rst),
            .wb_cyc_i(cyc[g]), .wb_stb_i(stb), .wb_we_i(we),
            .wb_adr_i(adr), .wb_dat_i(wdat),
            .wb_dat_o(rd), .wb_ack_o(ack), .wb_err_o(err),
            .c_o(c), .d_o(d), .issue_o(iss),
            .a_i(a), .b_i(b), .dbg_state(st)
        );

        // Downstream stage: correct results only exactly L cycles after issue.
        always @(posedge clk) begin
            if (rst) since <= 5'd0;
            else if (iss) since <= 5'd1;
            else if (since != 5'd0 && since != 5'd31) since <= since + 5'd1;
        end
        assign a = (since == 5'(L)) ? (c & d) : ~(c & d);
        assign b = (since == 5'(L)) ? (c | d) : ~(c | d);

        assign ack_w[g] = ack;
        assign err_w[g] = err;
        assign iss_w[g] = iss;
        assign dat_w[g] = rd;
        assign c_w[g]   = 32'(c);
        assign d_w[g]   = 32'(d);
    end

    // Transaction-level model: register contents plus the cycle a start was accepted.
    logic [31:0] m_opc [3], m_opd [3], m_ra [3], m_rb [3];
    logic [31:0] m_pc [3], m_pd [3], m_pa [3], m_pb [3];
    logic        m_done [3], m_pend [3];
    int unsigned m_t [3];

    function automatic void m_reset();
        for (int s = 0; s < 3; s++) begin
            m_opc[s] = 0; m_opd[s] = 0; m_ra[s] = 0; m_rb[s] = 0;
            m_pc[s] = 0; m_pd[s] = 0; m_pa[s] = 0; m_pb[s] = 0;
            m_done[s] = 0; m_pend[s] = 0; m_t[s] = 0;
        end
    endfunction

    // Results become visible LAT+2 cycles after the accepting request cycle.
    function automatic void m_advance(input int s, input int unsigned x);
        if (m_pend[s] && x >= m_t[s] + 32'(lat_of(s)) + 2) begin
            m_ra[s] = m_pa[s]; m_rb[s] = m_pb[s];
            m_done[s] = 1'b1; m_pend[s] = 1'b0;
        end
    endfunction

    function automatic logic m_busy(input int s, input int unsigned x);
        return m_pend[s] && x >= m_t[s] + 1 && x <= m_t[s] + 32'(lat_of(s)) + 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input int s, input logic w, input logic [4:0] a, input logic [31:0] dv,
                        output logic g_ack, output logic g_err, output logic [31:0] g_dat,
                        output logic e_err, output logic [31:0] e_dat);
        int unsigned x;
        logic bz;
        @(posedge clk); #1;
        x = cyc_cnt;
        cyc[s] = 1'b1; stb = 1'b1; we = w; adr = a; wdat = dv;
        m_advance(s, x);
        bz = m_busy(s, x);
        e_err = 1'b0; e_dat = 32'h0;
        case (a)
            5'h00: if (w) begin if (bz) e_err = 1'b1; else m_opc[s] = dv & mask_of(s); end
                   else e_dat = m_opc[s];
            5'h04: if (w) begin if (bz) e_err = 1'b1; else m_opd[s] = dv & mask_of(s); end
                   else e_dat = m_opd[s];
            5'h08: if (w) begin
                       if (bz) e_err = 1'b1;
                       else if (dv[0]) begin
                           m_pend[s] = 1'b1; m_t[s] = x; m_done[s] = 1'b0;
                           m_pc[s] = m_opc[s]; m_pd[s] = m_opd[s];
                           m_pa[s] = m_opc[s] & m_opd[s]; m_pb[s] = m_opc[s] | m_opd[s];
                       end
                   end
            5'h0C: if (w) e_err = 1'b1; else e_dat = {30'h0, m_done[s], bz};
            5'h10: if (w) e_err = 1'b1; else e_dat = m_ra[s];
            5'h14: if (w) e_err = 1'b1; else e_dat = m_rb[s];
            default: e_err = 1'b1;
        endcase
        @(posedge clk); #1;
        g_ack = ack_w[s]; g_err = err_w[s]; g_dat = dat_w[s];
        cyc[s] = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic do_op(input int s, input logic w, input logic [4:0] a, input logic [31:0] dv,
                         input string nm, output logic [31:0] rd);
        logic ga, ge, ee;
        logic [31:0] gd, ed;
        xfer(s, w, a, dv, ga, ge, gd, ee, ed);
        check({nm, "_ack"}, 32'(ga), 32'(!ee));
        check({nm, "_err"}, 32'(ge), 32'(ee));
        if (!w && !ee) check({nm, "_dat"}, gd, ed);
        rd = gd;
    endtask

    // Every cycle: issue_o only in the cycle after an accepted start; operands held while busy.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int s = 0; s < 3; s++) begin
                check($sformatf("issue%0d", s), 32'(iss_w[s]), 32'(m_pend[s] && cyc_cnt == m_t[s] + 1));
                if (m_pend[s] && cyc_cnt >= m_t[s] + 1 && cyc_cnt <= m_t[s] + 32'(lat_of(s)) + 1) begin
                    check($sformatf("c_hold%0d", s), c_w[s], m_pc[s]);
                    check($sformatf("d_hold%0d", s), d_w[s], m_pd[s]);
                end
            end
        end
    end

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic        x_err;
        logic [31:0] x_dat;
    } vec_t;

    vec_t tv [18];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic ga, ge, ee;
        logic [31:0] gd, ed;

        tv[0]  = '{1'b1, 5'h00, 32'h0F,  1'b0, 32'h0};
        tv[1]  = '{1'b1, 5'h04, 32'h3C,  1'b0, 32'h0};
        tv[2]  = '{1'b0, 5'h00, 32'h0,   1'b0, 32'h0F};
        tv[3]  = '{1'b1, 5'h08, 32'h1,   1'b0, 32'h0};
        tv[4]  = '{1'b0, 5'h10, 32'h0,   1'b0, 32'h0};
        tv[5]  = '{1'b0, 5'h0C, 32'h0,   1'b0, 32'h2};
        tv[6]  = '{1'b0, 5'h10, 32'h0,   1'b0, 32'h0C};
        tv[7]  = '{1'b0, 5'h14, 32'h0,   1'b0, 32'h3F};
        tv[8]  = '{1'b0, 5'h08, 32'h0,   1'b0, 32'h0};
        tv[9]  = '{1'b0, 5'h18, 32'h0,   1'b1, 32'h0};
        tv[10] = '{1'b1, 5'h10, 32'h55,  1'b1, 32'h0};
        tv[11] = '{1'b0, 5'h10, 32'h0,   1'b0, 32'h0C};
        tv[12] = '{1'b1, 5'h00, 32'h1A5, 1'b0, 32'h0};
        tv[13] = '{1'b0, 5'h00, 32'h0,   1'b0, 32'hA5};
        tv[14] = '{1'b1, 5'h08, 32'h0,   1'b0, 32'h0};
        tv[15] = '{1'b0, 5'h0C, 32'h0,   1'b0, 32'h2};
        tv[16] = '{1'b1, 5'h0C, 32'h3,   1'b1, 32'h0};
        tv[17] = '{1'b0, 5'h01, 32'h0,   1'b1, 32'h0};

        // Clock/reset
        rst = 1'b1; cyc = 3'b000; stb = 1'b0; we = 1'b0; adr = 5'h0; wdat = 32'h0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_ack%0d", s), 32'(ack_w[s]), 32'h0);
            check($sformatf("rst_err%0d", s), 32'(err_w[s]), 32'h0);
            check($sformatf("rst_dat%0d", s), dat_w[s], 32'h0);
            check($sformatf("rst_iss%0d", s), 32'(iss_w[s]), 32'h0);
            check($sformatf("rst_c%0d", s), c_w[s], 32'h0);
            check($sformatf("rst_d%0d", s), d_w[s], 32'h0);
        end
        mon_en = 1'b1;
        do_op(0, 1'b0, 5'h0C, 0, "rst_status", rd);
        check("rst_status_const", rd, 32'h0);
        do_op(0, 1'b0, 5'h10, 0, "rst_resa", rd);
        check("rst_resa_const", rd, 32'h0);

        // Register map and basic run, back-to-back table on the LAT=1 instance
        for (int i = 0; i < 18; i++) begin
            xfer(0, tv[i].w, tv[i].a, tv[i].d, ga, ge, gd, ee, ed);
            check($sformatf("tbl%0d_ack", i), 32'(ga), 32'(!tv[i].x_err));
            check($sformatf("tbl%0d_err", i), 32'(ge), 32'(tv[i].x_err));
            if (!tv[i].w && !tv[i].x_err) check($sformatf("tbl%0d_dat", i), gd, tv[i].x_dat);
        end

        // Strobe held for three cycles: responses must be separated by an idle cycle
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h0C;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ack%0d", k), 32'(ack_w[0]), (k == 0 || k == 2) ? 32'h1 : 32'h0);
            check($sformatf("hold_err%0d", k), 32'(err_w[0]), 32'h0);
            if (k == 2) begin cyc[0] = 1'b0; stb = 1'b0; end
        end

        // Request pending when reset hits gets no response
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h00; rst = 1'b1;
        m_reset();
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb = 1'b0; rst = 1'b0;
        check("rstpend_ack", 32'(ack_w[0]), 32'h0);
        check("rstpend_err", 32'(err_w[0]), 32'h0);
        @(posedge clk); #1;
        check("rstpend_ack_late", 32'(ack_w[0]), 32'h0);

        // LAT=4: issue, polled STATUS, capture timing
        do_op(1, 1'b1, 5'h00, 32'hA6, "l4_wc", rd);
        do_op(1, 1'b1, 5'h04, 32'h5C, "l4_wd", rd);
        do_op(1, 1'b1, 5'h08, 32'h1, "l4_start", rd);
        check("l4_issue", 32'(iss_w[1]), 32'h1);
        check("l4_c_at_issue", c_w[1], 32'hA6);
        do_op(1, 1'b0, 5'h0C, 0, "l4_poll1", rd);
        check("l4_poll1_const", rd, 32'h1);
        do_op(1, 1'b0, 5'h0C, 0, "l4_poll2", rd);
        check("l4_poll2_const", rd, 32'h1);
        do_op(1, 1'b0, 5'h0C, 0, "l4_poll3", rd);
        check("l4_poll3_const", rd, 32'h2);
        do_op(1, 1'b0, 5'h10, 0, "l4_resa", rd);
        check("l4_resa_const", rd, 32'h04);
        do_op(1, 1'b0, 5'h14, 0, "l4_resb", rd);
        check("l4_resb_const", rd, 32'hFE);

        // Operand write while busy is rejected and does not disturb the run
        do_op(1, 1'b1, 5'h00, 32'h33, "busy_wc", rd);
        do_op(1, 1'b1, 5'h04, 32'h0F, "busy_wd", rd);
        do_op(1, 1'b1, 5'h08, 32'h1, "busy_start", rd);
        xfer(1, 1'b1, 5'h00, 32'hFF, ga, ge, gd, ee, ed);
        check("busy_wr_err", 32'(ge), 32'h1);
        check("busy_wr_ack", 32'(ga), 32'h0);
        check("busy_c_held", c_w[1], 32'h33);
        repeat (6) @(posedge clk);
        do_op(1, 1'b0, 5'h00, 0, "busy_opc", rd);
        check("busy_opc_const", rd, 32'h33);
        do_op(1, 1'b0, 5'h10, 0, "busy_resa", rd);
        check("busy_resa_const", rd, 32'h03);
        do_op(1, 1'b0, 5'h14, 0, "busy_resb", rd);
        check("busy_resb_const", rd, 32'h3F);

        // Reset in WAIT aborts without capture
        @(posedge clk); #1 rst = 1'b1;
        m_reset();
        @(posedge clk); #1 rst = 1'b0;
        do_op(1, 1'b1, 5'h00, 32'h5A, "wr_wc", rd);
        do_op(1, 1'b1, 5'h04, 32'hC3, "wr_wd", rd);
        do_op(1, 1'b1, 5'h08, 32'h1, "wr_start", rd);
        @(posedge clk); #1 rst = 1'b1;
        m_reset();
        @(posedge clk); #1 rst = 1'b0;
        check("wrst_iss", 32'(iss_w[1]), 32'h0);
        check("wrst_c", c_w[1], 32'h0);
        check("wrst_d", d_w[1], 32'h0);
        check("wrst_ack", 32'(ack_w[1]), 32'h0);
        check("wrst_err", 32'(err_w[1]), 32'h0);
        check("wrst_dat", dat_w[1], 32'h0);
        repeat (6) @(posedge clk);
        do_op(1, 1'b0, 5'h10, 0, "wrst_resa", rd);
        check("wrst_resa_const", rd, 32'h0);
        do_op(1, 1'b0, 5'h14, 0, "wrst_resb", rd);
        check("wrst_resb_const", rd, 32'h0);
        do_op(1, 1'b0, 5'h0C, 0, "wrst_status", rd);
        check("wrst_status_const", rd, 32'h0);

        // WIDTH=1 truth table
        for (int i = 0; i < 4; i++) begin
            logic cv, dv;
            cv = i[1]; dv = i[0];
            exp_q.push_back(32'(cv & dv));
            exp_q.push_back(32'(cv | dv));
            do_op(2, 1'b1, 5'h00, {31'h7FFFFFFF, cv}, "tt_wc", rd);
            do_op(2, 1'b1, 5'h04, {31'h0, dv}, "tt_wd", rd);
            do_op(2, 1'b1, 5'h08, 32'h1, "tt_start", rd);
            repeat (3) @(posedge clk);
            do_op(2, 1'b0, 5'h10, 0, "tt_resa", rd);
            check($sformatf("tt%0d_and", i), rd, exp_q.pop_front());
            do_op(2, 1'b0, 5'h14, 0, "tt_resb", rd);
            check($sformatf("tt%0d_or", i), rd, exp_q.pop_front());
        end

        // Randomized traffic against the model, with random gaps
        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 70; n++) begin
                int r;
                logic [4:0] a;
                logic w;
                logic [31:0] dv;
                r = $urandom_range(0, 9);
                dv = $urandom;
                case (r)
                    0, 1: begin w = 1'b1; a = 5'h00; end
                    2, 3: begin w = 1'b1; a = 5'h04; end
                    4, 5: begin w = 1'b1; a = 5'h08; dv = 32'($urandom_range(0, 3)); end
                    6, 7: begin w = 1'b0; a = 5'(4 * $urandom_range(0, 5)); end
                    8:    begin w = 1'b1; a = 5'(4 * $urandom_range(3, 5)); end
                    default: begin w = 1'($urandom_range(0, 1)); a = 5'($urandom_range(0, 31)); end
                endcase
                do_op(s, w, a, dv, $sformatf("rnd%0d_%0d", s, n), rd);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_logic_feeder.md
WB_LOGIC_FEEDER -- requirements
Module: wb_logic_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width (1..32).
REQ-002 SHALL have parameter LAT, default 1, meaning downstream logic-stage latency in clk cycles (1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have Wishbone classic slave inputs: wb_cyc_i 1, wb_stb_i 1, wb_we_i 1, wb_adr_i 5 (byte address), wb_dat_i 32.
REQ-006 SHALL have Wishbone classic slave outputs: wb_dat_o 32, wb_ack_o 1, wb_err_o 1.
REQ-007 SHALL have downstream outputs: c_o WIDTH, d_o WIDTH (operands) and issue_o 1 (operands valid this cycle).
REQ-008 SHALL have downstream inputs: a_i WIDTH (AND result) and b_i WIDTH (OR result).

Function
REQ-009 SHALL decode registers: 0x00 OP_C (rw), 0x04 OP_D (rw), 0x08 CTRL (wo, bit0 = start), 0x0C STATUS (ro, bit0 busy, bit1 done), 0x10 RES_A (ro), 0x14 RES_B (ro); other addresses are unmapped.
REQ-010 SHALL respond to each cycle with wb_cyc_i&wb_stb_i high exactly one cycle later, pulsing wb_ack_o or wb_err_o for one cycle, never both, and never on consecutive cycles of the same transaction (one idle cycle between responses).
REQ-011 SHALL assert wb_err_o instead of wb_ack_o for: unmapped address, write to STATUS/RES_A/RES_B, write to OP_C/OP_D/CTRL while busy.
REQ-012 SHALL zero-extend WIDTH-bit values on reads; bits above WIDTH on OP_C/OP_D writes are ignored; reads of CTRL return 0.
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE.
REQ-014 IDLE: busy=0; an accepted write of CTRL bit0=1 moves to ISSUE on the next cycle and clears done.
REQ-015 ISSUE: issue_o=1 for exactly one cycle; c_o/d_o equal OP_C/OP_D and are held stable from ISSUE until the FSM returns to IDLE.
REQ-016 WAIT: counter loads LAT at ISSUE and decrements each cycle; when it reaches 0 the block samples a_i into RES_A and b_i into RES_B, i.e. LAT cycles after the issue_o cycle.
REQ-017 DONE: done=1, busy=0 for one cycle; then IDLE with done held until the next start.
REQ-018 busy SHALL be 1 in ISSUE and WAIT only.
REQ-019 CTRL write with bit0=0 SHALL be acknowledged with no effect.
REQ-020 A STATUS or RES read in the same cycle as capture SHALL return the pre-capture value (register read, no bypass).

Reset
REQ-021 On rst: FSM=IDLE, counter=0, OP_C=OP_D=RES_A=RES_B=0, done=0, wb_ack_o=wb_err_o=0, wb_dat_o=0, issue_o=0, c_o=d_o=0.
REQ-022 rst asserted mid-operation SHALL abort without capture; no ack/err SHALL be issued for a cycle pending at reset.

Structure
REQ-023 A shared package wb_logic_pkg SHALL hold the register offsets, the FSM state enum and the STATUS bit positions.
REQ-024 Register decode/ack/err logic SHALL be a sub-module wb_logic_regs; the FSM and counter stay in the top.

Verification
REQ-025 Write OP_C=0x0F, OP_D=0x3C, CTRL=1, LAT=1 -> issue_o one cycle, RES_A=0x0C, RES_B=0x3F, STATUS=0x2.
REQ-026 LAT=4, start -> capture exactly 4 cycles after issue_o; STATUS=0x1 polled during WAIT.
REQ-027 Write OP_C while busy -> wb_err_o, c_o unchanged, result unaffected.
REQ-028 Read 0x18 and write 0x10 -> wb_err_o each, no register change.
REQ-029 rst asserted in WAIT -> all outputs 0 next cycle, RES_A/RES_B stay 0, STATUS=0x0.
REQ-030 Sweep all four 1-bit combinations with WIDTH=1 -> RES_A/RES_B match AND/OR truth table.
